// File: rtl/multiplier_16bit_ctrl_if.sv
// -----------------------------------------------------------------------------
// multiplier_16bit_ctrl_if
//   Handshake and data bundle between the multi-cycle ALU (master) and the
//   shift-add multiplier controller (slave).
//
//   start        master -> slave  request a multiply (honoured in IDLE/DONE)
//   signed_mode  master -> slave  1 = two's-complement operands
//   a            master -> slave  multiplicand
//   b            master -> slave  multiplier
//   flush        master -> slave  cancel an operation in progress
//   busy         slave -> master  high while stepping
//   done         slave -> master  one-cycle pulse when product updates
//   product      slave -> master  result, held until the next completion
// -----------------------------------------------------------------------------
interface multiplier_16bit_ctrl_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, a, b, flush,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b, flush,
    output busy, done, product
  );
endinterface

// File: rtl/multiplier_16bit_ctrl.sv
// -----------------------------------------------------------------------------
// multiplier_16bit_ctrl
//   Sequential shift-add multiplier, one multiplier bit per clock. Produces a
//   32-bit signed or unsigned product of two 16-bit operands in 16 steps.
//
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of multiplier_16bit_ctrl_if (start/signed_mode/a/b/
//          flush in; busy/done/product out)
//
//   Timing: the edge that samples start enters RUN (busy rises). Steps happen
//   on the following 16 edges; the 16th step writes product and enters DONE,
//   which lasts one cycle (done high). A start seen in DONE restarts at once.
// -----------------------------------------------------------------------------
module multiplier_16bit_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multiplier_16bit_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;

  logic [WIDTH-1:0]   xr_reg;       // multiplicand
  logic [WIDTH-1:0]   yr_reg;       // multiplier bits out, product bits in
  logic [WIDTH:0]     sk_reg;       // partial sum, one guard bit
  logic [CW-1:0]      cnt_reg;      // step index
  logic               sm_reg;       // signed mode latched with start
  logic [2*WIDTH-1:0] product_reg;

  logic               load;
  logic               step;
  logic               last_step;

  logic [WIDTH:0]     xe;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     t;
  logic [WIDTH:0]     sk_next;
  logic [WIDTH-1:0]   yr_next;

  assign last_step = (cnt_reg == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // Step datapath. The top multiplier bit carries negative weight in signed
  // mode, so the last step subtracts instead of adding.
  // ---------------------------------------------------------------------------
  always_comb begin
    xe      = sm_reg ? {xr_reg[WIDTH-1], xr_reg} : {1'b0, xr_reg};
    addend  = yr_reg[0] ? xe : '0;
    if (sm_reg && last_step) begin
      t = sk_reg - addend;
    end else begin
      t = sk_reg + addend;
    end
    // Unsigned mode keeps t[16] as the carry, shifted into sk[15].
    sk_next = {(sm_reg ? t[WIDTH] : 1'b0), t[WIDTH:1]};
    yr_next = {t[0], yr_reg[WIDTH-1:1]};
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        // flush is meaningless here; start always wins
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // start is ignored while stepping
        if (bus.flush) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (last_step) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr_reg      <= '0;
      yr_reg      <= '0;
      sk_reg      <= '0;
      cnt_reg     <= '0;
      sm_reg      <= 1'b0;
      product_reg <= '0;
    end else if (load) begin
      xr_reg  <= bus.a;
      yr_reg  <= bus.b;
      sk_reg  <= '0;
      cnt_reg <= '0;
      sm_reg  <= bus.signed_mode;
    end else if (step) begin
      sk_reg  <= sk_next;
      yr_reg  <= yr_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (last_step) begin
        product_reg <= {sk_next[WIDTH-1:0], yr_next};
      end
    end
  end

  // busy and done decode mutually exclusive states, so they never overlap.
  assign bus.busy    = (state_reg == RUN);
  assign bus.done    = (state_reg == DONE);
  assign bus.product = product_reg;

endmodule

// File: tb/tb_multiplier_16bit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multiplier_16bit_ctrl
//   Directed vectors for multiplier_16bit_ctrl. The driver pushes expected
//   products and completion cycles into a scoreboard queue; a monitor pops
//   and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_multiplier_16bit_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [31:0] prod;
    int          due;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  multiplier_16bit_ctrl_if #(.WIDTH(16)) mif ();

  multiplier_16bit_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: checks every done pulse against the scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mif.busy && mif.done) begin
        n_vec++;
        n_err++;
        $display("FAIL busy_done_overlap: busy=%b done=%b, expected not both", mif.busy, mif.done);
      end
      if (mif.done) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: product=%h, expected no done", mif.product);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("txn %s: product=%h expected=%h done_cycle=%0d expected_cycle=%0d",
                   e.name, mif.product, e.prod, cyc, e.due);
          chk({e.name, "_product"}, mif.product, e.prod);
          chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic issue(input logic sm, input logic [15:0] av, input logic [15:0] bv,
                       input logic fl, input bit push, input logic [31:0] exp,
                       input string nm);
    @(negedge clk);
    mif.start       = 1'b1;
    mif.signed_mode = sm;
    mif.a           = av;
    mif.b           = bv;
    mif.flush       = fl;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.flush = 1'b0;
    chk({nm, "_busy_rise"}, {31'd0, mif.busy}, 32'd1);
    if (push) sb_q.push_back('{exp, cyc + 16, nm});
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: %0d results pending, expected 0", nm, sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    mif.start       = 1'b0;
    mif.signed_mode = 1'b0;
    mif.a           = '0;
    mif.b           = '0;
    mif.flush       = 1'b0;

    #1;
    chk("reset_busy",    {31'd0, mif.busy}, 32'd0);
    chk("reset_done",    {31'd0, mif.done}, 32'd0);
    chk("reset_product", mif.product,       32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Operand corners
    issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 32'hFFFE0001, "u_ffff_ffff"); drain("u_ffff_ffff");
    issue(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, 32'h40000000, "s_8000_8000"); drain("s_8000_8000");
    issue(1'b1, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 32'hC0008000, "s_7fff_8000"); drain("s_7fff_8000");
    issue(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 32'hFFFFFFFF, "s_ffff_0001"); drain("s_ffff_0001");
    issue(1'b1, 16'h0003, 16'hFFFE, 1'b0, 1'b1, 32'hFFFFFFFA, "s_0003_fffe"); drain("s_0003_fffe");
    issue(1'b0, 16'h0003, 16'hFFFE, 1'b0, 1'b1, 32'h0002FFFA, "u_0003_fffe"); drain("u_0003_fffe");

    // start while busy is ignored
    issue(1'b0, 16'd2, 16'd3, 1'b0, 1'b1, 32'h00000006, "busy_2x3");
    repeat (4) @(negedge clk);
    mif.start = 1'b1; mif.a = 16'd5; mif.b = 16'd7;
    @(negedge clk);
    mif.start = 1'b0;
    drain("busy_2x3");

    // start in the DONE cycle restarts with no idle gap
    issue(1'b0, 16'd2, 16'd3, 1'b0, 1'b1, 32'h00000006, "b2b_2x3");
    repeat (16) @(negedge clk);
    issue(1'b0, 16'd5, 16'd7, 1'b0, 1'b1, 32'h00000023, "b2b_5x7");
    drain("b2b_5x7");

    // flush partway through: no done, product held
    issue(1'b0, 16'h1234, 16'h5678, 1'b0, 1'b0, 32'd0, "flush_run");
    repeat (9) @(negedge clk);
    mif.flush = 1'b1;
    @(negedge clk);
    mif.flush = 1'b0;
    chk("flush_busy_low", {31'd0, mif.busy}, 32'd0);
    chk("flush_product_held", mif.product, 32'h00000023);
    repeat (20) @(negedge clk);
    chk("flush_product_still", mif.product, 32'h00000023);
    issue(1'b0, 16'h1234, 16'h5678, 1'b0, 1'b1, 32'h06260060, "rerun_1234_5678");
    drain("rerun_1234_5678");

    // flush together with start in IDLE: start accepted
    issue(1'b0, 16'd3, 16'd4, 1'b1, 1'b1, 32'h0000000C, "start_flush_idle");
    drain("start_flush_idle");

    // asynchronous reset mid-run
    issue(1'b0, 16'h1234, 16'h0002, 1'b0, 1'b0, 32'd0, "reset_run");
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy",    {31'd0, mif.busy}, 32'd0);
    chk("async_done",    {31'd0, mif.done}, 32'd0);
    chk("async_product", mif.product,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 16'h00FF, 16'h0101, 1'b0, 1'b1, 32'h0000FFFF, "post_reset");
    drain("post_reset");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
